// File: rtl/vote_accumulator_3b.sv
// Valid/ready accumulator that sums NUM_OPERANDS 3-bit operands through an external adder.
// Optional build macro VOTE_ACC_SATURATE_EN clamps the accumulator at 7 on carry-out.
module vote_accumulator_3b #(
   parameter int NUM_OPERANDS = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       clear,
   input  logic       in_valid,
   input  logic [2:0] in_data,
   output logic       in_ready,
   output logic [2:0] add_a,
   output logic [2:0] add_b,
   output logic       add_cin,
   input  logic [2:0] add_sum,
   input  logic [2:0] add_cout,
   output logic [2:0] result,
   output logic       overflow,
   output logic [2:0] count,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [2:0] LP_LAST = 3'(NUM_OPERANDS);

   state_t     r_state;
   state_t     w_next;
   logic [2:0] r_acc;
   logic [2:0] r_count;
   logic       r_ovf;
   logic       w_accept;
   logic       w_last;
   logic       w_restart;
   logic [2:0] w_acc_nxt;
   logic       w_unused;

   // Only the carry out of bit 2 matters; lower carries are internal to the adder.
   assign w_unused  = ^add_cout[1:0];

   assign w_accept  = in_valid && (r_state == S_CAPTURE);
   assign w_last    = w_accept && ((r_count + 3'd1) == LP_LAST);
   assign w_restart = (r_state == S_IDLE) && start;

`ifdef VOTE_ACC_SATURATE_EN
   assign w_acc_nxt = add_cout[2] ? 3'b111 : add_sum;
`else
   assign w_acc_nxt = add_sum;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (start)  w_next = S_CAPTURE;
         S_CAPTURE: if (w_last) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
      if (clear) begin
         w_next = S_IDLE;
      end
   end

   // clear and a fresh start both zero the run; clear also beats a same-cycle accept.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_acc   <= 3'd0;
         r_count <= 3'd0;
         r_ovf   <= 1'b0;
      end else if (clear || w_restart) begin
         r_acc   <= 3'd0;
         r_count <= 3'd0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_acc   <= w_acc_nxt;
         r_count <= r_count + 3'd1;
         r_ovf   <= r_ovf | add_cout[2];
      end
   end

   assign in_ready = (r_state == S_CAPTURE);
   assign busy     = (r_state == S_CAPTURE);
   assign done     = (r_state == S_DONE);
   assign add_a    = r_acc;
   assign add_b    = in_data;
   assign add_cin  = 1'b0;
   assign result   = r_acc;
   assign overflow = r_ovf;
   assign count    = r_count;

endmodule

// File: tb/tb_vote_accumulator_3b.sv
// Directed bench for vote_accumulator_3b with a behavioural ripple adder in the loop.
module tb_vote_accumulator_3b;

   logic       clock;
   logic       reset;
   logic       start;
   logic       clear;
   logic       in_valid;
   logic [2:0] in_data;
   logic       in_ready;
   logic [2:0] add_a;
   logic [2:0] add_b;
   logic       add_cin;
   logic [2:0] add_sum;
   logic [2:0] add_cout;
   logic [2:0] result;
   logic       overflow;
   logic [2:0] count;
   logic       busy;
   logic       done;

   int n_cmp;
   int n_fail;

   vote_accumulator_3b #(.NUM_OPERANDS(4)) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .clear    (clear),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .result   (result),
      .overflow (overflow),
      .count    (count),
      .busy     (busy),
      .done     (done)
   );

   // Environment model of the external ripple adder.
   logic tb_c;
   always_comb begin
      tb_c     = add_cin;
      add_sum  = 3'd0;
      add_cout = 3'd0;
      for (int i = 0; i < 3; i++) begin
         add_sum[i]  = add_a[i] ^ add_b[i] ^ tb_c;
         tb_c        = (add_a[i] & add_b[i]) | (tb_c & (add_a[i] ^ add_b[i]));
         add_cout[i] = tb_c;
      end
   end

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0][2:0] op;
      logic [3:0][1:0] gap;
      logic [2:0]      exp_res;
      logic            exp_ovf;
   } vec_t;

   vec_t vecs[5];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic set_vec(input int k, input int o0, input int o1, input int o2, input int o3,
                          input int g0, input int g1, input int g2, input int g3,
                          input int res, input int ovf);
      vecs[k].op[0]   = 3'(o0);
      vecs[k].op[1]   = 3'(o1);
      vecs[k].op[2]   = 3'(o2);
      vecs[k].op[3]   = 3'(o3);
      vecs[k].gap[0]  = 2'(g0);
      vecs[k].gap[1]  = 2'(g1);
      vecs[k].gap[2]  = 2'(g2);
      vecs[k].gap[3]  = 2'(g3);
      vecs[k].exp_res = 3'(res);
      vecs[k].exp_ovf = 1'(ovf);
   endtask

   task automatic run(input int k);
      int cyc;
      int exp_cyc;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      exp_cyc = 5;
      chk("start_busy", {7'd0, busy}, 8'd1);
      chk("start_ready", {7'd0, in_ready}, 8'd1);
      chk("start_result", {5'd0, result}, 8'd0);
      chk("start_count", {5'd0, count}, 8'd0);
      chk("start_ovf", {7'd0, overflow}, 8'd0);
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < int'(vecs[k].gap[i]); g++) begin
            in_valid = 1'b0;
            start    = 1'b1;
            tick();
            start    = 1'b0;
            cyc++;
            exp_cyc++;
            chk("stall_count", {5'd0, count}, 8'(i));
            chk("stall_busy", {7'd0, busy}, 8'd1);
         end
         in_valid = 1'b1;
         in_data  = vecs[k].op[i];
         tick();
         in_valid = 1'b0;
         cyc++;
         if (i < 3) begin
            chk("acc_count", {5'd0, count}, 8'(i + 1));
            chk("acc_done_low", {7'd0, done}, 8'd0);
         end
      end
      chk("done_high", {7'd0, done}, 8'd1);
      chk("done_cycle", 8'(cyc), 8'(exp_cyc));
      chk("done_ready_low", {7'd0, in_ready}, 8'd0);
      chk("run_result", {5'd0, result}, {5'd0, vecs[k].exp_res});
      chk("run_ovf", {7'd0, overflow}, {7'd0, vecs[k].exp_ovf});
      chk("run_count", {5'd0, count}, 8'd4);
      // Offer an operand and a start during DONE; neither may be taken.
      in_valid = 1'b1;
      in_data  = 3'd3;
      start    = 1'b1;
      tick();
      in_valid = 1'b0;
      start    = 1'b0;
      chk("post_done_low", {7'd0, done}, 8'd0);
      chk("post_busy_low", {7'd0, busy}, 8'd0);
      chk("post_result", {5'd0, result}, {5'd0, vecs[k].exp_res});
      chk("post_count", {5'd0, count}, 8'd4);
   endtask

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = 3'd0;

      set_vec(0, 1, 2, 1, 3, 0, 0, 0, 0, 7, 0);
`ifdef VOTE_ACC_SATURATE_EN
      set_vec(1, 6, 3, 0, 0, 0, 0, 0, 0, 7, 1);
      set_vec(3, 7, 1, 2, 0, 0, 1, 0, 0, 7, 1);
`else
      set_vec(1, 6, 3, 0, 0, 0, 0, 0, 0, 1, 1);
      set_vec(3, 7, 1, 2, 0, 0, 1, 0, 0, 2, 1);
`endif
      set_vec(2, 2, 2, 2, 1, 0, 1, 2, 3, 7, 0);
      set_vec(4, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0);

      repeat (3) tick();
      chk("rst_result", {5'd0, result}, 8'd0);
      chk("rst_count", {5'd0, count}, 8'd0);
      chk("rst_ovf", {7'd0, overflow}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_ready", {7'd0, in_ready}, 8'd0);
      chk("rst_done", {7'd0, done}, 8'd0);
      chk("rst_add_cin", {7'd0, add_cin}, 8'd0);
      reset = 1'b0;
      tick();
      chk("idle_busy", {7'd0, busy}, 8'd0);

      for (int k = 0; k < 5; k++) begin
         run(k);
      end

      // Back-to-back: previous result stays visible until the next start edge.
      run(1);
      chk("b2b_prev_result", {5'd0, result}, {5'd0, vecs[1].exp_res});
      chk("b2b_prev_ovf", {7'd0, overflow}, 8'd1);
      run(0);

      // clear beats a same-cycle accept.
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 3'd6;
      tick();
      in_data = 3'd3;
      tick();
      chk("clr_pre_result", {5'd0, result}, 8'd1);
      chk("clr_pre_ovf", {7'd0, overflow}, 8'd1);
      in_data = 3'd5;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_busy", {7'd0, busy}, 8'd0);
      chk("clr_result", {5'd0, result}, 8'd0);
      chk("clr_count", {5'd0, count}, 8'd0);
      chk("clr_ovf", {7'd0, overflow}, 8'd0);
      tick();
      in_valid = 1'b0;
      chk("clr_stays_idle", {7'd0, busy}, 8'd0);
      chk("clr_no_add", {5'd0, result}, 8'd0);
      clear = 1'b1;
      start = 1'b1;
      tick();
      clear = 1'b0;
      start = 1'b0;
      chk("clr_over_start", {7'd0, busy}, 8'd0);

      // Asynchronous reset in the middle of a run.
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 3'd3;
      tick();
      in_data = 3'd2;
      tick();
      in_valid = 1'b0;
      chk("mid_pre_result", {5'd0, result}, 8'd5);
      chk("mid_pre_count", {5'd0, count}, 8'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_result", {5'd0, result}, 8'd0);
      chk("mid_rst_count", {5'd0, count}, 8'd0);
      chk("mid_rst_ovf", {7'd0, overflow}, 8'd0);
      chk("mid_rst_busy", {7'd0, busy}, 8'd0);
      chk("mid_rst_ready", {7'd0, in_ready}, 8'd0);
      chk("mid_rst_done", {7'd0, done}, 8'd0);
      tick();
      reset = 1'b0;
      tick();
      chk("mid_rst_idle", {7'd0, busy}, 8'd0);

      run(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
